// File: rtl/uart_buffered_pkg.sv
// uart_buffered_pkg
//   Shared definitions for the buffered UART: bus register addresses,
//   STATUS bit positions, RX/TX state encodings and the divisor clamp.
package uart_buffered_pkg;

   localparam logic [1:0] ADDR_STATUS  = 2'd0;
   localparam logic [1:0] ADDR_DATA    = 2'd1;
   localparam logic [1:0] ADDR_DIVISOR = 2'd2;
   localparam logic [1:0] ADDR_CTRL    = 2'd3;

   localparam int ST_TX_FULL   = 15;
   localparam int ST_RX_AVAIL  = 14;
   localparam int ST_TX_IDLE   = 13;
   localparam int ST_OVERRUN   = 12;
   localparam int ST_FRAME_ERR = 11;
   localparam int ST_PAR_ERR   = 10;

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

   // Divisors below 2 would make the half-bit wait zero; clamp to 2.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d < 16'd2) ? 16'd2 : d;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
//   Single-clock FIFO, W bits wide, 2**AW entries deep. rdata shows the
//   head entry combinationally (valid when !empty).
// Ports:
//   clk, reset_b     clock, async active-low reset
//   push, wdata      write request/data; ignored when full unless popping too
//   pop, rdata       read request (ignored when empty) / head data
//   full, empty      occupancy flags
//   count            entries held, 0..2**AW
module uart_sync_fifo #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset_b,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   localparam int DEPTH = 2**AW;
   localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == FULL_CNT);
   assign count   = cnt_q;
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem_q[rd_q];

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata;
   end

endmodule

// File: rtl/uart_buffered.sv
// uart_buffered
//   Buffered UART on the 16-bit system bus: TX/RX FIFOs, runtime divisor,
//   sticky overrun/framing/parity flags and a registered interrupt.
//   Optional feature macro: UART_BUFFERED_PARITY_EN (even parity bit on
//   TX, checked on RX; without it STATUS[10] is constant 0).
// Ports:
//   clk, reset_b        clock, async active-low reset
//   cs_b, rnw, a, din   bus access (one clk per access), 0=STATUS 1=DATA
//                       2=DIVISOR 3=CTRL
//   dout                read data, combinational from a and state
//   rxd / txd           serial in (asynchronous) / serial out (idle high)
//   irq                 (ie_rx & rx_avail) | (ie_tx & tx_idle), registered
module uart_buffered
   import uart_buffered_pkg::*;
#(
   parameter int CLKSPEED  = 32000000,
   parameter int BAUD      = 115200,
   parameter int DIVISOR   = CLKSPEED / BAUD,
   parameter int DATA_BITS = 8,
   parameter int FIFO_AW   = 4
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        cs_b,
   input  logic        rnw,
   input  logic [1:0]  a,
   input  logic [15:0] din,
   output logic [15:0] dout,
   input  logic        rxd,
   output logic        txd,
   output logic        irq
);
`ifdef UART_BUFFERED_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   // ---------------- bus decode and registers ----------------
   logic        wr_en, rd_en, tx_push, rx_pop, stat_rd;
   logic [15:0] div_q, div_m1, half_m1;
   logic [1:0]  ctrl_q;
   logic        overrun_q, frame_q, par_q, irq_q;

   assign wr_en   = ~cs_b & ~rnw;
   assign rd_en   = ~cs_b & rnw;
   assign tx_push = wr_en & (a == ADDR_DATA);
   assign rx_pop  = rd_en & (a == ADDR_DATA);
   assign stat_rd = rd_en & (a == ADDR_STATUS);

   // Counters reload from these only at bit boundaries, so a divisor
   // write never stretches or shortens the bit in progress.
   assign div_m1  = eff_div(div_q) - 16'd1;
   assign half_m1 = (eff_div(div_q) >> 1) - 16'd1;

   // ---------------- FIFOs ----------------
   logic [DATA_BITS-1:0] tx_rdata, rx_rdata;
   logic                 tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;
   logic [FIFO_AW:0]     tx_count, rx_count;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;

   uart_sync_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
      .clk(clk), .reset_b(reset_b),
      .push(tx_push), .wdata(din[DATA_BITS-1:0]),
      .pop(tx_pop), .rdata(tx_rdata),
      .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   uart_sync_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
      .clk(clk), .reset_b(reset_b),
      .push(rx_push), .wdata(rx_sh_q),
      .pop(rx_pop), .rdata(rx_rdata),
      .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   // ---------------- TX FSM ----------------
   tx_state_t            tx_state_q, tx_state_d;
   logic [15:0]          tx_cnt_q, tx_cnt_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic [2:0]           tx_bit_q, tx_bit_d;
   logic                 tx_par_q, tx_par_d, txd_q, txd_d, tx_last, tx_load, tx_idle;

   assign tx_last = (tx_cnt_q == '0);
   assign tx_idle = (tx_count == '0) & (tx_state_q == TX_IDLE);

   // txd is registered from the next state so the line changes exactly on
   // the bit boundary and never glitches.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_sh_d    = tx_sh_q;
      tx_bit_d   = tx_bit_q;
      tx_par_d   = tx_par_q;
      txd_d      = txd_q;
      tx_load    = 1'b0;
      if (tx_state_q != TX_IDLE) tx_cnt_d = tx_cnt_q - 16'd1;
      unique case (tx_state_q)
         TX_IDLE: begin
            txd_d = 1'b1;
            if (!tx_empty) tx_load = 1'b1;
         end
         TX_START: if (tx_last) begin
            tx_state_d = TX_DATA;
            tx_cnt_d   = div_m1;
            tx_bit_d   = '0;
            txd_d      = tx_sh_q[0];
            tx_sh_d    = tx_sh_q >> 1;
         end
         TX_DATA: if (tx_last) begin
            tx_cnt_d = div_m1;
            if (tx_bit_q == LAST_BIT) begin
               tx_state_d = PAR_EN ? TX_PAR : TX_STOP;
               txd_d      = PAR_EN ? tx_par_q : 1'b1;
            end else begin
               tx_bit_d = tx_bit_q + 3'd1;
               txd_d    = tx_sh_q[0];
               tx_sh_d  = tx_sh_q >> 1;
            end
         end
         TX_PAR: if (tx_last) begin
            tx_state_d = TX_STOP;
            tx_cnt_d   = div_m1;
            txd_d      = 1'b1;
         end
         TX_STOP: if (tx_last) begin
            // Chain straight into the next start bit: no idle gap.
            if (!tx_empty) tx_load = 1'b1;
            else begin
               tx_state_d = TX_IDLE;
               txd_d      = 1'b1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      if (tx_load) begin
         tx_state_d = TX_START;
         tx_cnt_d   = div_m1;
         tx_sh_d    = tx_rdata;
         tx_par_d   = ^tx_rdata;
         txd_d      = 1'b0;
      end
   end

   assign tx_pop = tx_load;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_sh_q    <= '0;
         tx_bit_q   <= '0;
         tx_par_q   <= 1'b0;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_sh_q    <= tx_sh_d;
         tx_bit_q   <= tx_bit_d;
         tx_par_q   <= tx_par_d;
         txd_q      <= txd_d;
      end
   end

   assign txd = txd_q;

   // ---------------- RX path ----------------
   rx_state_t   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic        s1_q, s2_q, prev_q, rx_last, frame_set, par_set, ovr_set;

   assign rx_last = (rx_cnt_q == '0);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_sh_d    = rx_sh_q;
      rx_bit_d   = rx_bit_q;
      rx_push    = 1'b0;
      frame_set  = 1'b0;
      par_set    = 1'b0;
      if (rx_state_q != RX_IDLE) rx_cnt_d = rx_cnt_q - 16'd1;
      unique case (rx_state_q)
         RX_IDLE: if (prev_q & ~s2_q) begin
            rx_state_d = RX_START;
            rx_cnt_d   = half_m1;
         end
         RX_START: if (rx_last) begin
            // Line back high at mid start bit: treat as a glitch.
            if (s2_q) rx_state_d = RX_IDLE;
            else begin
               rx_state_d = RX_DATA;
               rx_cnt_d   = div_m1;
               rx_bit_d   = '0;
            end
         end
         RX_DATA: if (rx_last) begin
            rx_cnt_d = div_m1;
            rx_sh_d  = {s2_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == LAST_BIT) rx_state_d = PAR_EN ? RX_PAR : RX_STOP;
            else                      rx_bit_d   = rx_bit_q + 3'd1;
         end
         RX_PAR: if (rx_last) begin
            par_set    = s2_q ^ (^rx_sh_q);
            rx_state_d = RX_STOP;
            rx_cnt_d   = div_m1;
         end
         RX_STOP: if (rx_last) begin
            rx_push    = 1'b1;
            frame_set  = ~s2_q;
            rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // The FIFO drops the push itself; here we only flag that it happened.
   assign ovr_set = rx_push & rx_full & ~rx_pop;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         s1_q       <= 1'b1;
         s2_q       <= 1'b1;
         prev_q     <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_sh_q    <= '0;
         rx_bit_q   <= '0;
      end else begin
         s1_q       <= rxd;
         s2_q       <= s1_q;
         prev_q     <= s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_sh_q    <= rx_sh_d;
         rx_bit_q   <= rx_bit_d;
      end
   end

   // ---------------- registers, sticky flags, irq ----------------
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         div_q     <= 16'(DIVISOR);
         ctrl_q    <= '0;
         overrun_q <= 1'b0;
         frame_q   <= 1'b0;
         par_q     <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         if (wr_en && a == ADDR_DIVISOR) div_q  <= din;
         if (wr_en && a == ADDR_CTRL)    ctrl_q <= din[1:0];
         // Set has priority over the STATUS-read clear.
         overrun_q <= ovr_set   | (overrun_q & ~stat_rd);
         frame_q   <= frame_set | (frame_q   & ~stat_rd);
         par_q     <= par_set   | (par_q     & ~stat_rd);
         irq_q     <= (ctrl_q[0] & (rx_count != '0)) | (ctrl_q[1] & tx_idle);
      end
   end

   assign irq = irq_q;

   always_comb begin
      dout = '0;
      unique case (a)
         ADDR_STATUS: begin
            dout[ST_TX_FULL]   = tx_full;
            dout[ST_RX_AVAIL]  = (rx_count != '0);
            dout[ST_TX_IDLE]   = tx_idle;
            dout[ST_OVERRUN]   = overrun_q;
            dout[ST_FRAME_ERR] = frame_q;
            dout[ST_PAR_ERR]   = par_q & PAR_EN;
         end
         ADDR_DATA:    if (!rx_empty) dout[DATA_BITS-1:0] = rx_rdata;
         ADDR_DIVISOR: dout = div_q;
         default:      dout[1:0] = ctrl_q;
      endcase
   end

endmodule
